// File: rtl/mips_mc_main_control.sv
// rtl/mips_mc_main_control.sv - multicycle MIPS main control FSM
module mips_mc_main_control #(
  parameter logic MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       instr_done,
  output logic       illegal_seen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   rdy;

  // With the handshake disabled, memory is assumed to complete in one cycle.
  assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state        = state_q;
  assign illegal_seen = illegal_q;

  // State and sticky illegal flag; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: opcode is only consulted in DECODE and MEM_ADR (IR is frozen there).
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADR;
        else if (opcode == OP_RTYP)             state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDI_EX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (rdy) state_d = S_MEM_WB;
      S_MEM_WR:  if (rdy) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALU_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; strobes are forced low while reset is held.
  always_comb begin
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEM_ADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = rdy;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      alu_op        = 2'b00;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_main_control.sv
// tb/tb_mips_mc_main_control.sv - testbench for mips_mc_main_control
module tb_mips_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;

  logic [1:0] alu_op, alu_src_b, pc_src;
  logic       alu_src_a, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, pc_write, pc_write_cond, instr_done, illegal_seen;
  logic [3:0] state;

  logic [1:0] h_alu_op, h_alu_src_b, h_pc_src;
  logic       h_alu_src_a, h_i_or_d, h_mem_read, h_mem_write, h_ir_write, h_reg_dst;
  logic       h_mem_to_reg, h_reg_write, h_pc_write, h_pc_write_cond, h_instr_done, h_illegal_seen;
  logic [3:0] h_state;

  always #5 clk = ~clk;

  mips_mc_main_control #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .instr_done(instr_done), .illegal_seen(illegal_seen),
    .state(state)
  );

  mips_mc_main_control #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(h_alu_op), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .pc_src(h_pc_src),
    .i_or_d(h_i_or_d), .mem_read(h_mem_read), .mem_write(h_mem_write), .ir_write(h_ir_write),
    .reg_dst(h_reg_dst), .mem_to_reg(h_mem_to_reg), .reg_write(h_reg_write), .pc_write(h_pc_write),
    .pc_write_cond(h_pc_write_cond), .instr_done(h_instr_done), .illegal_seen(h_illegal_seen),
    .state(h_state)
  );

  logic [16:0] outs;
  assign outs = {alu_op, alu_src_a, alu_src_b, pc_src, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, pc_write, pc_write_cond, instr_done};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobe vector for a given state, straight from the per-state output table.
  function automatic logic [16:0] exp_out(input int s, input logic mr);
    logic [1:0] aop, asb, psrc;
    logic asa, iod, mrd, mwr, irw, rdst, m2r, rw, pcw, pcwc, done;
    aop = 0; asb = 0; psrc = 0;
    asa = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; pcw = 0; pcwc = 0; done = 0;
    case (s)
      0:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:    asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:    begin iod = 1; mrd = 1; end
      4:    begin m2r = 1; rw = 1; done = 1; end
      5:    begin iod = 1; mwr = 1; done = mr; end
      6:    begin asa = 1; aop = 2'b10; end
      7:    begin rdst = 1; rw = 1; done = 1; end
      8:    begin asa = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; done = 1; end
      10:   begin rw = 1; done = 1; end
      11:   begin psrc = 2'b10; pcw = 1; done = 1; end
      default: ;
    endcase
    return {aop, asa, asb, psrc, iod, mrd, mwr, irw, rdst, m2r, rw, pcw, pcwc, done};
  endfunction

  // Instruction-level model: the list of states an opcode walks through.
  int path[$];
  task automatic load_route(input logic [5:0] op);
    case (op)
      LW:      path = '{0, 1, 2, 3, 4};
      SW:      path = '{0, 1, 2, 5};
      RT:      path = '{0, 1, 6, 7};
      BEQ:     path = '{0, 1, 8};
      ADDI:    path = '{0, 1, 9, 10};
      JMP:     path = '{0, 1, 11};
      default: path = '{0, 1};
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP);
  endfunction

  // Leaves the bench at posedge+1 in a fresh FETCH cycle.
  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_one(input bit nohs, output int lat, output int dones);
    lat = 0; dones = 0;
    do begin
      #1;
      lat++;
      if (nohs ? h_instr_done : instr_done) dones++;
      @(posedge clk); #1;
    end while ((nohs ? h_state : state) != 4'd0 && lat < 20);
  endtask

  typedef struct {
    logic [5:0] op;
    int         lat;
    int         dones;
    logic       ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, dn;
    vecs[0] = '{LW,   5, 1, 1'b0};
    vecs[1] = '{SW,   4, 1, 1'b0};
    vecs[2] = '{RT,   4, 1, 1'b0};
    vecs[3] = '{ADDI, 4, 1, 1'b0};
    vecs[4] = '{BEQ,  3, 1, 1'b0};
    vecs[5] = '{JMP,  3, 1, 1'b0};
    vecs[6] = '{6'b111111, 2, 0, 1'b1};

    // Reset state: strobes low while rst_n is held.
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_strobes", {mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond, instr_done}, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_illegal", illegal_seen, 0);
    do_reset();

    // Latency table with mem_ready tied high.
    foreach (vecs[i]) begin
      do_reset();
      opcode = vecs[i].op;
      run_one(1'b0, lat, dn);
      chk($sformatf("lat_op%02h", vecs[i].op), lat, vecs[i].lat);
      chk($sformatf("done_op%02h", vecs[i].op), dn, vecs[i].dones);
      chk($sformatf("ill_op%02h", vecs[i].op), illegal_seen, vecs[i].ill);
    end

    // lw with MEM_RD held off for three cycles: 8 cycles total.
    do_reset();
    opcode = LW;
    begin
      int seq[8];
      int mr[8];
      int cyc;
      seq = '{0, 1, 2, 3, 3, 3, 3, 4};
      mr  = '{1, 1, 1, 0, 0, 0, 1, 1};
      cyc = 0;
      for (int c = 0; c < 8; c++) begin
        mem_ready = mr[c][0];
        #1;
        chk($sformatf("lw_stall_state%0d", c), state, seq[c]);
        chk($sformatf("lw_stall_out%0d", c), outs, exp_out(seq[c], mr[c][0]));
        cyc++;
        @(posedge clk); #1;
      end
      chk("lw_stall_back", state, 0);
      chk("lw_stall_cycles", cyc, 8);
    end

    // beq strobes in BRANCH.
    do_reset();
    mem_ready = 1'b1;
    opcode = BEQ;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    chk("beq_state", state, 8);
    chk("beq_alu_op", alu_op, 2'b01);
    chk("beq_pc_src", pc_src, 2'b01);
    chk("beq_pcwc_pcw", {pc_write_cond, pc_write}, 2'b10);
    @(posedge clk); #1;

    // Illegal opcode is sticky across later instructions until reset.
    do_reset();
    opcode = 6'b111111;
    #1; chk("ill_fetch", illegal_seen, 0);
    @(posedge clk); #2;
    chk("ill_decode_state", state, 1);
    chk("ill_decode_flag", illegal_seen, 0);
    @(posedge clk); #1;
    chk("ill_back_fetch", state, 0);
    chk("ill_set", illegal_seen, 1);
    opcode = RT;
    run_one(1'b0, lat, dn);
    chk("ill_sticky_lat", lat, 4);
    chk("ill_sticky", illegal_seen, 1);
    rst_n = 1'b0; #1;
    chk("ill_cleared", illegal_seen, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Reset pulsed in MEM_WR while waiting on memory.
    opcode = SW;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    chk("sw_wr_state", state, 5);
    chk("sw_wr_mem_write", mem_write, 1);
    @(posedge clk); #2;
    chk("sw_wr_hold", {state, mem_write, instr_done}, {4'd5, 1'b1, 1'b0});
    rst_n = 1'b0; #1;
    chk("sw_rst_mem_write", mem_write, 0);
    chk("sw_rst_state", state, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    mem_ready = 1'b1; #1;
    chk("sw_after_state", state, 0);
    chk("sw_after_mem_read", mem_read, 1);
    @(posedge clk); #1;

    // No-handshake instance ignores mem_ready.
    mem_ready = 1'b0;
    do_reset();
    opcode = LW;
    run_one(1'b1, lat, dn);
    chk("nohs_lw_lat", lat, 5);
    chk("nohs_lw_done", dn, 1);

    // Randomized instruction stream against the route model.
    mem_ready = 1'b1;
    do_reset();
    begin
      logic [5:0] ops[8];
      logic [5:0] cur_op;
      bit m_ill;
      ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111, 6'b000101};
      m_ill = 0;
      cur_op = RT;
      path = {};
      for (int c = 0; c < 600; c++) begin
        if (path.size() == 0) begin
          cur_op = ops[$urandom_range(0, 7)];
          load_route(cur_op);
          opcode = cur_op;
        end
        mem_ready = ($urandom_range(0, 9) < 7);
        #1;
        chk($sformatf("rnd_state_c%0d", c), state, path[0]);
        chk($sformatf("rnd_out_c%0d", c), outs, exp_out(path[0], mem_ready));
        chk($sformatf("rnd_ill_c%0d", c), illegal_seen, m_ill);
        if (!((path[0] == 0 || path[0] == 3 || path[0] == 5) && !mem_ready)) begin
          if (path[0] == 1 && !is_legal(cur_op)) m_ill = 1;
          void'(path.pop_front());
        end
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
